shift_unit_seq: RTL and testbench
=================================

SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising clock edge only.
REQ-002 Parameter: WIDTH, default 8, data width; it SHALL be a power of two and at least 4.
REQ-003 Derived: AMT_W = clog2(WIDTH), the shift-amount width.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 in_op  input  3  operation code.
REQ-009 in_amt  input  AMT_W  shift/rotate amount, 0..WIDTH-1.
REQ-010 in_data  input  WIDTH  operand.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  WIDTH  result.
REQ-014 out_carry  output  1  last bit moved across the word boundary.
REQ-015 out_err  output  1  request carried an illegal op code.

Function
REQ-016 Op codes SHALL be: 000 logical right, 001 logical left, 010 arithmetic right (MSB replicated), 011 logical left (alias of 001), 100 rotate right, 101 rotate left; 110 and 111 are illegal.
REQ-017 The FSM SHALL have states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL occur on an edge where in_valid=1 and in_ready=1; op, amt and data SHALL be captured then and later input changes SHALL be ignored.
REQ-019 On acceptance with legal op and amt>0 the FSM SHALL enter SHIFT with counter=amt and carry=0.
REQ-020 In SHIFT the block SHALL perform exactly one 1-bit step per cycle, decrement the counter, and enter DONE on the step where the counter reaches 0.
REQ-021 Per step: right ops SHALL shift out bit 0 into carry; left ops SHALL shift out bit WIDTH-1 into carry; rotate right SHALL move bit 0 to bit WIDTH-1; rotate left SHALL move bit WIDTH-1 to bit 0; carry SHALL take the moved/dropped bit.
REQ-022 Inserted fill SHALL be 0 for logical shifts and the original MSB for arithmetic right.
REQ-023 On acceptance with legal op and amt=0 the FSM SHALL go directly to DONE with out_data=in_data, out_carry=0.
REQ-024 On acceptance with an illegal op the FSM SHALL go directly to DONE with out_data=0, out_carry=0, out_err=1, regardless of amt.
REQ-025 out_err SHALL be 0 for every legal-op result.
REQ-026 Latency SHALL be amt+1 cycles from the acceptance edge to out_valid=1 (1 cycle for amt=0 or illegal op).
REQ-027 out_valid SHALL be 1 exactly in DONE; out_data, out_carry and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 In DONE with out_ready=1 the FSM SHALL return to IDLE on that edge; a new request SHALL NOT be accepted on the same edge (minimum one bubble cycle between results).
REQ-029 out_ready SHALL be ignored outside DONE; in_valid SHALL be ignored outside IDLE.

Reset
REQ-030 While rst_n=0 at a clock edge the FSM SHALL go to IDLE and out_valid, out_data, out_carry, out_err, counter SHALL become 0; in_ready SHALL be 1 after that edge.
REQ-031 Reset asserted during SHIFT or DONE SHALL discard the transaction with no result produced.

Verification (WIDTH=8)
REQ-032 op 000, data 8'hB6, amt 3 -> out_data 8'h16, out_carry 1, out_valid 4 cycles after acceptance.
REQ-033 op 010, data 8'h96, amt 2 -> out_data 8'hE5, out_carry 1; op 100, data 8'h81, amt 1 -> 8'hC0, carry 1; op 101, data 8'h81, amt 3 -> 8'h0C, carry 0.
REQ-034 op 001, data 8'h5A, amt 0 -> out_data 8'h5A, carry 0, latency 1; op 110, data 8'hFF, amt 5 -> out_data 8'h00, out_err 1, latency 1.
REQ-035 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_data -> outputs unchanged, in_ready 0, no extra acceptance; out_ready=1 -> IDLE next edge, in_ready 1.
REQ-036 rst_n=0 for one edge mid-SHIFT (amt 7, 3 steps done) -> IDLE, all outputs 0, no out_valid; next request processes correctly.
REQ-037 Back-to-back random legal requests with random out_ready, checked against a reference model of REQ-016..REQ-023, incl. amt=WIDTH-1 for every op.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Sequential shift/rotate unit: one 1-bit step per cycle with valid/ready handshakes.
// Left shifts drop the MSB into carry; right shifts and rotates move bit 0 or the MSB across the boundary.
module shift_unit_seq #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SRL     = 3'b000;
    localparam logic [2:0] OP_SLL     = 3'b001;
    localparam logic [2:0] OP_SRA     = 3'b010;
    localparam logic [2:0] OP_SLL_ALT = 3'b011;
    localparam logic [2:0] OP_ROR     = 3'b100;
    localparam logic [2:0] OP_ROL     = 3'b101;

    state_t           state;
    logic [AMT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH:0]   step_c;
    logic             illegal_c;

    assign illegal_c = in_op[2] & in_op[1];

    // One 1-bit step of the captured op, packed as {carry, data}.
    // The MSB of the working word never changes under SRA, so it is the fill.
    always_comb begin
        step_c = {1'b0, work};
        case (op_q)
            OP_SRL:             step_c = {work[0], 1'b0, work[WIDTH-1:1]};
            OP_SRA:             step_c = {work[0], work[WIDTH-1], work[WIDTH-1:1]};
            OP_SLL, OP_SLL_ALT: step_c = {work[WIDTH-1], work[WIDTH-2:0], 1'b0};
            OP_ROR:             step_c = {work[0], work[0], work[WIDTH-1:1]};
            OP_ROL:             step_c = {work[WIDTH-1], work[WIDTH-2:0], work[WIDTH-1]};
            default:            step_c = {1'b0, work};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_err   <= 1'b0;
            cnt       <= '0;
            op_q      <= '0;
            work      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        work     <= in_data;
                        cnt      <= in_amt;
                        in_ready <= 1'b0;
                        if (illegal_c) begin
                            state     <= DONE;
                            cnt       <= '0;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_carry <= 1'b0;
                            out_err   <= 1'b1;
                        end else if (in_amt == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                            out_carry <= 1'b0;
                            out_err   <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= step_c[WIDTH-1:0];
                    cnt  <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= step_c[WIDTH-1:0];
                        out_carry <= step_c[WIDTH];
                        out_err   <= 1'b0;
                    end
                end
                DONE: begin
                    // Returning to IDLE forces a bubble before the next acceptance.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: transaction-level model checked every cycle, plus literal vectors.
module tb_shift_unit_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_err;

    always #5 clk = ~clk;

    shift_unit_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_err   (out_err)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       err;
    } res_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] data;
        logic [2:0] amt;
        logic [7:0] r_data;
        logic       r_carry;
        logic       r_err;
        logic [3:0] lat;
    } vec_t;

    vec_t tbl [8] = '{
        '{3'b000, 8'hB6, 3'd3, 8'h16, 1'b1, 1'b0, 4'd4},
        '{3'b010, 8'h96, 3'd2, 8'hE5, 1'b1, 1'b0, 4'd3},
        '{3'b100, 8'h81, 3'd1, 8'hC0, 1'b1, 1'b0, 4'd2},
        '{3'b101, 8'h81, 3'd3, 8'h0C, 1'b0, 1'b0, 4'd4},
        '{3'b001, 8'h5A, 3'd0, 8'h5A, 1'b0, 1'b0, 4'd1},
        '{3'b110, 8'hFF, 3'd5, 8'h00, 1'b0, 1'b1, 4'd1},
        '{3'b011, 8'h81, 3'd1, 8'h02, 1'b1, 1'b0, 4'd2},
        '{3'b111, 8'h12, 3'd0, 8'h00, 1'b0, 1'b1, 4'd1}
    };

    // Whole-word result computed directly with integer shifts.
    function automatic res_t model(input logic [2:0] op, input logic [7:0] d, input int amt);
        res_t r;
        int   u;
        int   s;
        int   v;
        u = int'(d);
        s = int'($signed(d));
        r = '0;
        case (op)
            3'b000: begin
                r.data  = 8'(u >> amt);
                r.carry = (amt > 0) ? 1'((u >> (amt - 1)) & 1) : 1'b0;
            end
            3'b010: begin
                r.data  = 8'(s >>> amt);
                r.carry = (amt > 0) ? 1'((u >> (amt - 1)) & 1) : 1'b0;
            end
            3'b001, 3'b011: begin
                v       = u << amt;
                r.data  = 8'(v);
                r.carry = 1'((v >> 8) & 1);
            end
            3'b100: begin
                v       = (u >> amt) | (u << (8 - amt));
                r.data  = 8'(v);
                r.carry = (amt > 0) ? r.data[7] : 1'b0;
            end
            3'b101: begin
                v       = (u << amt) | (u >> (8 - amt));
                r.data  = 8'(v);
                r.carry = (amt > 0) ? r.data[0] : 1'b0;
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    int   errors = 0;
    int   checks = 0;
    int   n_acc = 0;
    int   rem = 0;
    int   lat = 0;
    int   lit_idx = 0;
    bit   armed = 1'b0;
    bit   after_rst = 1'b0;
    bit   pend = 1'b0;
    bit   valid_now = 1'b0;
    bit   first_valid = 1'b0;
    bit   lit_on = 1'b0;
    bit   pinned = 1'b0;
    bit   finished = 1'b0;
    res_t exp_r = '0;

    int   n_sent = 0;
    int   tmo_cnt = 0;
    bit   done = 1'b0;
    bit   rand_mode = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: check the cycle just observed, then predict the next edge.
    always @(negedge clk) begin
        res_t pr;
        if (!pinned) begin
            pinned = 1'b1;
            for (int i = 0; i < 8; i++) begin
                pr = model(tbl[i].op, tbl[i].data, int'(tbl[i].amt));
                chk("pin_data", int'(pr.data), int'(tbl[i].r_data));
                chk("pin_carry", int'(pr.carry), int'(tbl[i].r_carry));
                chk("pin_err", int'(pr.err), int'(tbl[i].r_err));
            end
        end
        if (armed) begin
            chk("out_valid", int'(out_valid), int'(valid_now));
            chk("in_ready", int'(in_ready), int'(!pend && !valid_now));
            if (valid_now) begin
                chk("out_data", int'(out_data), int'(exp_r.data));
                chk("out_carry", int'(out_carry), int'(exp_r.carry));
                chk("out_err", int'(out_err), int'(exp_r.err));
            end
            if (first_valid && lit_on) begin
                chk("lit_data", int'(out_data), int'(tbl[lit_idx].r_data));
                chk("lit_carry", int'(out_carry), int'(tbl[lit_idx].r_carry));
                chk("lit_err", int'(out_err), int'(tbl[lit_idx].r_err));
                chk("lit_latency", lat, int'(tbl[lit_idx].lat));
            end
            if (after_rst) begin
                chk("rst_data", int'(out_data), 0);
                chk("rst_carry", int'(out_carry), 0);
                chk("rst_err", int'(out_err), 0);
            end
        end
        if (first_valid) lit_on = 1'b0;
        after_rst   = 1'b0;
        first_valid = 1'b0;
        if (!rst_n) begin
            armed     = 1'b1;
            after_rst = 1'b1;
            pend      = 1'b0;
            valid_now = 1'b0;
            lit_on    = 1'b0;
        end else if (armed) begin
            if (valid_now) begin
                if (out_ready) valid_now = 1'b0;
            end else if (pend) begin
                rem--;
                lat++;
                if (rem == 0) begin
                    pend        = 1'b0;
                    valid_now   = 1'b1;
                    first_valid = 1'b1;
                end
            end else if (in_valid) begin
                n_acc++;
                exp_r  = model(in_op, in_data, int'(in_amt));
                lat    = 1;
                lit_on = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    if (tbl[i].op == in_op && tbl[i].data == in_data && tbl[i].amt == in_amt) begin
                        lit_on  = 1'b1;
                        lit_idx = i;
                    end
                end
                if (exp_r.err || in_amt == '0) begin
                    valid_now   = 1'b1;
                    first_valid = 1'b1;
                end else begin
                    pend = 1'b1;
                    rem  = int'(in_amt);
                end
            end
        end
        if (done && !finished) begin
            finished = 1'b1;
            chk("timeouts", tmo_cnt, 0);
            chk("accept_count", n_acc, n_sent);
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [2:0] a);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        n = 0;
        while (!in_ready && n < 60) begin
            tick();
            n++;
        end
        if (in_ready) begin
            tick();
            n_sent++;
        end else begin
            tmo_cnt++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        if (!out_valid) tmo_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].op, tbl[i].data, tbl[i].amt);
            wait_valid();
            tick();
        end

        // Stall the result while the request side churns.
        out_ready = 1'b0;
        send(3'b101, 8'h3C, 3'd2);
        wait_valid();
        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_op    = 3'($urandom);
            in_amt   = 3'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset three steps into a 7-step shift.
        send(3'b000, 8'hC3, 3'd7);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        send(3'b000, 8'hB6, 3'd3);
        wait_valid();
        tick();

        for (int op = 0; op < 8; op++) begin
            send(3'(op), 8'($urandom), 3'd7);
            wait_valid();
            tick();
        end

        rand_mode = 1'b1;
        repeat (400) begin
            if ($urandom_range(0, 7) == 0) tick();
            if ($urandom_range(0, 9) == 0)
                send(3'($urandom_range(6, 7)), 8'($urandom), 3'($urandom));
            else
                send(3'($urandom_range(0, 5)), 8'($urandom), 3'($urandom));
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();

        done = 1'b1;
        repeat (10) tick();
        $display("FAIL summary: compare process did not finish");
        $fatal(1);
    end

endmodule
